// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two memory clients, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the clients-plus-memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic              req1_lock;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU LSU (port 0) and the
// program loader (port 1), with a bounded burst lock for port 1 and one-cycle response pulses.
module mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    mem_arbiter_if.slave bus
);
    localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOCK);

    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             pend_v_q, pend_v_d;
    logic             pend_port_q, pend_port_d;

    logic grant_v_s;
    logic grant_port_s;
    logic lock_hold_s;

    // Grant selection; port 1 keeps the grant only while its lock budget lasts
    always_comb begin
        lock_hold_s  = last_q && bus.req1_lock && (lock_cnt_q < MAX_CNT);
        grant_v_s    = 1'b0;
        grant_port_s = 1'b0;
        if (!rstn_i) begin
            grant_v_s    = 1'b0;
            grant_port_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant_v_s    = 1'b1;
            grant_port_s = lock_hold_s ? 1'b1 : ~last_q;
        end else if (bus.req0_valid) begin
            grant_v_s    = 1'b1;
            grant_port_s = 1'b0;
        end else if (bus.req1_valid) begin
            grant_v_s    = 1'b1;
            grant_port_s = 1'b1;
        end else begin
            grant_v_s    = 1'b0;
            grant_port_s = 1'b0;
        end
    end

    // Memory drive, handshake and response decode
    always_comb begin
        bus.req0_ready = grant_v_s && !grant_port_s;
        bus.req1_ready = grant_v_s && grant_port_s;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = bus.req0_addr;
        bus.mem_wdata  = bus.req0_wdata;
        if (grant_port_s) begin
            bus.mem_we    = grant_v_s && bus.req1_we;
            bus.mem_addr  = bus.req1_addr;
            bus.mem_wdata = bus.req1_wdata;
        end else begin
            bus.mem_we    = grant_v_s && bus.req0_we;
            bus.mem_addr  = bus.req0_addr;
            bus.mem_wdata = bus.req0_wdata;
        end
        bus.rsp0_valid = pend_v_q && !pend_port_q;
        bus.rsp1_valid = pend_v_q && pend_port_q;
        bus.rsp0_rdata = (pend_v_q && !pend_port_q) ? bus.mem_rdata : '0;
        bus.rsp1_rdata = (pend_v_q && pend_port_q) ? bus.mem_rdata : '0;
    end

    // Next-state for round-robin pointer, pending response and lock budget
    always_comb begin
        last_d      = last_q;
        pend_v_d    = grant_v_s;
        pend_port_d = pend_port_q;
        lock_cnt_d  = lock_cnt_q;
        if (grant_v_s) begin
            last_d      = grant_port_s;
            pend_port_d = grant_port_s;
        end else begin
            last_d      = last_q;
            pend_port_d = pend_port_q;
        end
        // A locked grant following a port 1 grant extends the burst; any fresh one restarts at 1
        if (!bus.req1_lock) begin
            lock_cnt_d = '0;
        end else if (grant_v_s && grant_port_s) begin
            if (last_q) begin
                lock_cnt_d = (lock_cnt_q < MAX_CNT) ? lock_cnt_q + CNT_W'(1) : MAX_CNT;
            end else begin
                lock_cnt_d = CNT_W'(1);
            end
        end else if (grant_v_s) begin
            lock_cnt_d = '0;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // State registers; reset favours port 0 on the first contention
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q      <= 1'b1;
            lock_cnt_q  <= '0;
            pend_v_q    <= 1'b0;
            pend_port_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            pend_v_q    <= pend_v_d;
            pend_port_q <= pend_port_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 1024x32 memory and a response scoreboard.
module tb_mem_arbiter;
    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(4)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory macro: synchronous write, registered read address
    logic [31:0] mem_arr [1024];
    logic [9:0]  rd_addr_q;
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'(i);
            mem_init_done <= 1'b1;
        end else if (bus.mem_we) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
        end
        rd_addr_q <= bus.mem_addr;
    end
    assign bus.mem_rdata = mem_arr[rd_addr_q];

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [1024];

    // Scoreboard: push expected response on each issue, pop and compare on the following cycle
    initial begin : scoreboard
        exp_t e;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);
        forever begin
            @(negedge clk);
            #3;
            if (!rstn) begin
                exp_q.delete();
                checks++;
                if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.req0_ready !== 1'b0 ||
                    bus.req1_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_reset_outputs: rsp0=%b rsp1=%b rdy0=%b rdy1=%b we=%b, required all 0",
                             bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, bus.mem_we);
                end
            end else begin
                checks++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.port == 1'b0) begin
                        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp1_rdata !== 32'h0 ||
                            (!e.we && bus.rsp0_rdata !== e.data)) begin
                            failures++;
                            $display("FAIL sb_rsp_port0: v0=%b v1=%b d0=%h d1=%h, required v0=1 v1=0 d0=%h (we=%b) d1=0",
                                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata, e.data, e.we);
                        end
                    end else begin
                        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp0_rdata !== 32'h0 ||
                            (!e.we && bus.rsp1_rdata !== e.data)) begin
                            failures++;
                            $display("FAIL sb_rsp_port1: v0=%b v1=%b d0=%h d1=%h, required v0=0 v1=1 d1=%h (we=%b) d0=0",
                                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata, e.data, e.we);
                        end
                    end
                end else if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_spurious_rsp: rsp0=%b rsp1=%b, required both 0",
                             bus.rsp0_valid, bus.rsp1_valid);
                end
                checks++;
                if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin
                    failures++;
                    $display("FAIL sb_double_grant: rdy0=%b rdy1=%b, required at most one",
                             bus.req0_ready, bus.req1_ready);
                end
                if (bus.req0_valid && bus.req0_ready) begin
                    exp_q.push_back('{port: 1'b0, we: bus.req0_we,
                                      data: bus.req0_we ? bus.req0_wdata : ref_mem[bus.req0_addr]});
                    if (bus.req0_we) ref_mem[bus.req0_addr] = bus.req0_wdata;
                end
                if (bus.req1_valid && bus.req1_ready) begin
                    exp_q.push_back('{port: 1'b1, we: bus.req1_we,
                                      data: bus.req1_we ? bus.req1_wdata : ref_mem[bus.req1_addr]});
                    if (bus.req1_we) ref_mem[bus.req1_addr] = bus.req1_wdata;
                end
            end
        end
    end

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req0_we    = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_we    = 1'b0;
        bus.req1_lock  = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 10'd10; bus.req0_wdata = 32'h0;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 10'd20; bus.req1_wdata = 32'h0;
        bus.req1_lock  = 1'b0;
        @(negedge clk);
        #3;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
            bus.rsp0_rdata !== 32'h0 || bus.rsp1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: rdy0=%b rdy1=%b we=%b rsp0=%b rsp1=%b d0=%h d1=%h, required all 0",
                     bus.req0_ready, bus.req1_ready, bus.mem_we, bus.rsp0_valid, bus.rsp1_valid,
                     bus.rsp0_rdata, bus.rsp1_rdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++;
            if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL reset_first_order[%0d]: rdy0=%b rdy1=%b, required rdy0=%b rdy1=%b",
                         k, bus.req0_ready, bus.req1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_write_read();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 10'd5; bus.req0_wdata = 32'hDEADBEEF;
        #3;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_issue: rdy0=%b we=%b wdata=%h, required 1 1 deadbeef",
                     bus.req0_ready, bus.mem_we, bus.mem_wdata);
        end
        @(negedge clk);
        bus.req0_we = 1'b0;
        #3;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack: rdy0=%b we=%b rsp0=%b rsp1=%b, required 1 0 1 0",
                     bus.req0_ready, bus.mem_we, bus.rsp0_valid, bus.rsp1_valid);
        end
        @(negedge clk);
        idle();
        #3;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 32'hDEADBEEF || bus.rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_data: rsp0=%b d0=%h rsp1=%b, required 1 deadbeef 0",
                     bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid);
        end
        @(negedge clk);
        #3;
        checks++;
        if (bus.rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL rsp_single_pulse: rsp0=%b, required 0", bus.rsp0_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [9:0] a0 = 10'd100;
        logic [9:0] a1 = 10'd200;
        logic       exp_port = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = a0;
            bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = a1; bus.req1_lock = 1'b0;
            #3;
            checks++;
            if (bus.req0_ready !== !exp_port || bus.req1_ready !== exp_port) begin
                failures++;
                $display("FAIL contention_alt[%0d]: rdy0=%b rdy1=%b, required grant to port %0d",
                         k, bus.req0_ready, bus.req1_ready, exp_port);
            end
            if (bus.req0_ready) a0 = a0 + 10'd1;
            if (bus.req1_ready) a1 = a1 + 10'd1;
            exp_port = ~exp_port;
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_lock_bound();
        logic [9:0] a1 = 10'd300;
        int         wait_cycles = 0;
        logic       got0 = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 10'd50;
        #3;
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL lock_prime: rdy0=%b, required 1", bus.req0_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 8 && !got0; k++) begin
            bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_lock = 1'b1; bus.req1_addr = a1;
            #3;
            wait_cycles++;
            checks++;
            if (bus.req1_ready !== (k < 4) || bus.req0_ready !== (k == 4)) begin
                failures++;
                $display("FAIL lock_seq[%0d]: rdy0=%b rdy1=%b, required rdy0=%b rdy1=%b",
                         k, bus.req0_ready, bus.req1_ready, (k == 4), (k < 4));
            end
            if (bus.req1_ready) a1 = a1 + 10'd1;
            if (bus.req0_ready) got0 = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!got0 || wait_cycles > 5) begin
            failures++;
            $display("FAIL lock_wait_bound: port0 granted=%b after %0d cycles, required grant within 5",
                     got0, wait_cycles);
        end
        bus.req0_valid = 1'b0;
    endtask

    task automatic test_lock_no_contention();
        logic [9:0] a1 = 10'd400;
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_lock = 1'b1; bus.req1_addr = a1;
            #3;
            checks++;
            if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
                failures++;
                $display("FAIL lock_stream[%0d]: rdy0=%b rdy1=%b, required 0 1",
                         k, bus.req0_ready, bus.req1_ready);
            end
            if (bus.req1_ready) a1 = a1 + 10'd1;
            @(negedge clk);
        end
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 10'd60;
        bus.req1_addr  = a1;
        #3;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_saturated_yield: rdy0=%b rdy1=%b, required 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_midflight_reset();
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 10'd7; bus.req1_lock = 1'b0;
        #3;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL midflight_issue: rdy1=%b, required 1", bus.req1_ready);
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        bus.req1_valid = 1'b0;
        #2;
        checks++;
        if (bus.rsp1_valid !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_drop: rsp0=%b rsp1=%b, required 0 0", bus.rsp0_valid, bus.rsp1_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 10'd70;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 10'd80;
        #3;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_first_grant: rdy0=%b rdy1=%b, required 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rstn = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = 10'd0; bus.req0_wdata = 32'h0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = 10'd0; bus.req1_wdata = 32'h0;
        bus.req1_lock  = 1'b0;
        test_reset();
        test_write_read();
        test_contention();
        test_lock_bound();
        test_lock_no_contention();
        test_midflight_reset();
        repeat (3) @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
